// File: rtl/alu_seq.sv
// Registered ALU with shifts, iterative shift-add multiply and NZVC flags.
// start/ready/valid handshake lets the control FSM stall on long ops.
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  localparam logic [SH_W-1:0] LAST = SH_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic             sf_q, sf_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             c_q, c_d;

  logic is_pass, is_add, is_sub, is_and, is_or;
  logic is_xor, is_lsl, is_lsr, is_mul;

  assign is_pass = (op == 4'b0000);
  assign is_add  = (op == 4'b0010);
  assign is_sub  = (op == 4'b0011);
  assign is_and  = (op == 4'b0100);
  assign is_or   = (op == 4'b0101);
  assign is_xor  = (op == 4'b0110);
  assign is_lsl  = (op == 4'b1000);
  assign is_lsr  = (op == 4'b1001);
  assign is_mul  = (op == 4'b1010);

  logic [WIDTH-1:0] b_x, sum, alu_y, acc_n;
  logic             c_out, c_msb, alu_ok, arith;

  assign b_x = is_sub ? ~B : B;
  assign {c_out, sum} = {1'b0, A} + {1'b0, b_x}
                      + {{WIDTH{1'b0}}, is_sub};
  assign c_msb = A[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1];
  assign arith = is_add | is_sub;
  assign acc_n = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    alu_y  = '0;
    alu_ok = 1'b1;
    unique case (1'b1)
      is_pass: alu_y = B;
      is_add:  alu_y = sum;
      is_sub:  alu_y = sum;
      is_and:  alu_y = A & B;
      is_or:   alu_y = A | B;
      is_xor:  alu_y = A ^ B;
      is_lsl:  alu_y = A << B[SH_W-1:0];
      is_lsr:  alu_y = A >> B[SH_W-1:0];
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sf_d     = sf_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sf_d = set_flags;
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = A;
            mplier_d = B;
          end else begin
            state_d  = S_DONE;
            result_d = alu_y;
            if (set_flags && alu_ok) begin
              n_d = alu_y[WIDTH-1];
              z_d = (alu_y == '0);
              c_d = arith & c_out;
              v_d = arith & (c_msb ^ c_out);
            end
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH_W'(1);
        // no bits left means acc is already final
        if ((mplier_d == '0) || (cnt_q == LAST)) begin
          state_d  = S_DONE;
          result_d = acc_n;
          if (sf_q) begin
            n_d = acc_n[WIDTH-1];
            z_d = (acc_n == '0);
            c_d = 1'b0;
            v_d = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sf_q     <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sf_q     <= sf_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign valid     = (state_q == S_DONE);
  assign result    = result_q;
  assign negative  = n_q;
  assign zero      = z_q;
  assign overflow  = v_q;
  assign carry_out = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 and WIDTH=64 instances, vector table,
// handshake corner sequences and random ops against an arithmetic model.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start8, start64, sf;
  logic [3:0]  op;
  logic [63:0] a, b;

  logic        rdy8, val8, n8, z8, v8, c8;
  logic [7:0]  r8;
  logic        rdy64, val64, n64, z64, v64, c64;
  logic [63:0] r64;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op),
    .set_flags(sf), .A(a[7:0]), .B(b[7:0]),
    .ready(rdy8), .valid(val8), .result(r8),
    .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8)
  );

  alu_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .op(op),
    .set_flags(sf), .A(a), .B(b),
    .ready(rdy64), .valid(val64), .result(r64),
    .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: result and NZVC straight from the operation definitions.
  function automatic logic [67:0] model(input int w, input logic [3:0] o,
      input logic s, input logic [63:0] x, input logic [63:0] y,
      input logic [3:0] fin);
    logic [63:0] mask, xm, ym, r;
    logic [64:0] full;
    logic legal, c, v, sx, sy, sr;
    mask = (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
    xm = x & mask;
    ym = y & mask;
    r = '0; c = 0; v = 0; legal = 1; full = '0;
    case (o)
      4'b0000: r = ym;
      4'b0010: full = {1'b0, xm} + {1'b0, ym};
      4'b0011: full = {1'b0, xm} + {1'b0, (~ym) & mask} + 65'h1;
      4'b0100: r = xm & ym;
      4'b0101: r = xm | ym;
      4'b0110: r = xm ^ ym;
      4'b1000: r = (xm << (ym % w)) & mask;
      4'b1001: r = xm >> (ym % w);
      4'b1010: r = (xm * ym) & mask;
      default: legal = 0;
    endcase
    if (o == 4'b0010 || o == 4'b0011) begin
      r  = full[63:0] & mask;
      c  = full[w];
      sx = xm[w-1];
      sy = ym[w-1];
      sr = r[w-1];
      if (o == 4'b0010) v = (sx == sy) && (sr != sx);
      else              v = (sx != sy) && (sr != sx);
    end
    if (legal && s)
      return {r, r[w-1], (r == 0), v, c};
    return {r, fin};
  endfunction

  task automatic do_op(input bit w, input logic [3:0] o, input logic s,
                       input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] res, output logic [3:0] f,
                       output int lat);
    @(negedge clk);
    chk("ready_before_start", w ? rdy64 : rdy8, 1);
    op = o; sf = s; a = x; b = y;
    if (w) start64 = 1; else start8 = 1;
    @(posedge clk);
    #1;
    start8 = 0; start64 = 0;
    a = ~x; b = {$urandom, $urandom}; sf = ~s; op = 4'($urandom);
    lat = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (w ? val64 : val8) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout op=%b width64=%0d", o, w);
    end
    res = w ? r64 : {56'h0, r8};
    f = w ? {n64, z64, v64, c64} : {n8, z8, v8, c8};
  endtask

  typedef struct {
    logic [3:0] op;
    logic       sf;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t tv[14];
  logic [3:0] legal_ops[9];
  logic [3:0] f8, f64, fo, o;
  logic [63:0] res, x, y;
  logic [67:0] exp;
  int lat, ww;
  bit w, seen;

  initial begin
    tv[0]  = '{4'b0010, 1'b1, 8'h7F, 8'h01, 8'h80, 4'b1010};
    tv[1]  = '{4'b0011, 1'b1, 8'h05, 8'h05, 8'h00, 4'b0101};
    tv[2]  = '{4'b0100, 1'b0, 8'hF0, 8'h0F, 8'h00, 4'b0101};
    tv[3]  = '{4'b1000, 1'b0, 8'h81, 8'h09, 8'h02, 4'b0101};
    tv[4]  = '{4'b1001, 1'b0, 8'h80, 8'h07, 8'h01, 4'b0101};
    tv[5]  = '{4'b1111, 1'b1, 8'h12, 8'h34, 8'h00, 4'b0101};
    tv[6]  = '{4'b1010, 1'b1, 8'h0D, 8'h0B, 8'h8F, 4'b1000};
    tv[7]  = '{4'b0011, 1'b1, 8'h00, 8'h01, 8'hFF, 4'b1000};
    tv[8]  = '{4'b0010, 1'b1, 8'hFF, 8'h01, 8'h00, 4'b0101};
    tv[9]  = '{4'b0000, 1'b1, 8'h11, 8'h80, 8'h80, 4'b1000};
    tv[10] = '{4'b0011, 1'b1, 8'h80, 8'h01, 8'h7F, 4'b0011};
    tv[11] = '{4'b0101, 1'b0, 8'h50, 8'h05, 8'h55, 4'b0011};
    tv[12] = '{4'b0110, 1'b1, 8'hAA, 8'hAA, 8'h00, 4'b0100};
    tv[13] = '{4'b1010, 1'b1, 8'h37, 8'h00, 8'h00, 4'b0100};
    legal_ops = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};

    reset = 0; start8 = 0; start64 = 0; sf = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    chk("rst_ready64", rdy64, 1);
    chk("rst_valid64", val64, 0);
    chk("rst_result64", r64, 0);
    chk("rst_flags64", {n64, z64, v64, c64}, 0);
    chk("rst_ready8", rdy8, 1);
    chk("rst_flags8", {n8, z8, v8, c8}, 0);

    for (int i = 0; i < 14; i++) begin
      do_op(0, tv[i].op, tv[i].sf, {56'h0, tv[i].a}, {56'h0, tv[i].b},
            res, fo, lat);
      chk($sformatf("tv%0d_result", i), res, {56'h0, tv[i].r});
      chk($sformatf("tv%0d_flags", i), fo, tv[i].f);
      if (tv[i].op == 4'b1010) chk($sformatf("tv%0d_lat", i), lat <= 9, 1);
      else                     chk($sformatf("tv%0d_lat", i), lat, 1);
    end

    // Busy MUL with start held high and garbage operands on the bus.
    @(negedge clk);
    op = 4'b1010; sf = 1; a = 64'h0D; b = 64'h0B; start8 = 1;
    @(posedge clk);
    #1;
    op = 4'b0010; sf = 0; a = 64'hFF; b = 64'hFF;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (val8) begin
        lat = i;
        break;
      end
      chk($sformatf("mul_busy_ready_c%0d", i), rdy8, 0);
    end
    start8 = 0;
    chk("mul_lat_le9", (lat >= 1) && (lat <= 9), 1);
    chk("mul_result", {56'h0, r8}, 64'h8F);
    chk("mul_flags", {n8, z8, v8, c8}, 4'b1000);
    @(negedge clk);
    chk("mul_valid_one_cycle", val8, 0);
    chk("mul_result_held", {56'h0, r8}, 64'h8F);
    f8 = 4'b1000;
    f64 = 4'b0000;

    do_op(1, 4'b1010, 0, {64{1'b1}}, 64'h2, res, fo, lat);
    chk("mul64_result", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mul64_flags", fo, f64);
    chk("mul64_lat", (lat >= 1) && (lat <= 65), 1);

    // Reset lands in the middle of a long 64-bit multiply.
    @(negedge clk);
    op = 4'b1010; sf = 1; a = {64{1'b1}}; b = {64{1'b1}}; start64 = 1;
    @(posedge clk);
    #1;
    start64 = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen |= val64;
    end
    chk("abort_busy_ready", rdy64, 0);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("abort_ready", rdy64, 1);
    chk("abort_result", r64, 0);
    chk("abort_flags", {n64, z64, v64, c64}, 0);
    repeat (70) begin
      @(negedge clk);
      seen |= val64;
    end
    chk("abort_no_valid", seen, 0);
    f8 = 0;
    f64 = 0;

    for (int i = 0; i < 160; i++) begin
      w = i[0];
      ww = w ? 64 : 8;
      o = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) o = legal_ops[$urandom_range(0, 8)];
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) y = y & 64'hFF;
      sf = 1'($urandom_range(0, 1));
      exp = model(ww, o, sf, x, y, w ? f64 : f8);
      do_op(w, o, sf, x, y, res, fo, lat);
      chk($sformatf("rnd%0d_w%0d_op%b_result", i, ww, o), res, exp[67:4]);
      chk($sformatf("rnd%0d_w%0d_op%b_flags", i, ww, o), fo, exp[3:0]);
      if (o == 4'b1010)
        chk($sformatf("rnd%0d_lat", i), (lat >= 1) && (lat <= ww + 1), 1);
      else
        chk($sformatf("rnd%0d_lat", i), lat, 1);
      if (w) f64 = exp[3:0];
      else   f8 = exp[3:0];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Adds shift operations, an iterative shift-add multiplier, and a persistent NZVC flag register with per-op flag-set enable (ADDS/SUBS-style).
- Sits between register-file read and writeback in the multicycle datapath.
- Uses a start/ready/valid handshake so the control FSM can stall on long operations.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 4, power of two).
- SH_W, $clog2(WIDTH), shift-amount width taken from B[SH_W-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request; op accepted when start && ready
- op  input  4  operation select, decoded below
- set_flags  input  1  sampled at accept; 1 = update NZVC at completion
- A  input  WIDTH  operand A, sampled at accept
- B  input  WIDTH  operand B / shift amount, sampled at accept
- ready  output  1  1 = idle and able to accept
- valid  output  1  one-cycle pulse; result holds the new value
- result  output  WIDTH  registered result, held until next completion
- negative  output  1  N flag (registered)
- zero  output  1  Z flag (registered)
- overflow  output  1  V flag (registered)
- carry_out  output  1  C flag (registered)

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; result, all flags and valid go to 0; ready goes to 1.
  - Reset aborts any in-flight MUL with no valid pulse.
- Op encoding:
  - 0000 PASS B
  - 0010 ADD A+B
  - 0011 SUB A+~B+1
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 1000 LSL A<<B[SH_W-1:0]
  - 1001 LSR A>>B[SH_W-1:0] (logical)
  - 1010 MUL, low WIDTH bits of A*B (unsigned; equal to the low half of the signed product)
  - All other codes are illegal: result=0, valid still pulses, flags never updated even if set_flags=1.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accept of a non-MUL op: next state DONE; result registered at the same edge.
  - IDLE, accept of MUL: next state MUL; counter=0, accumulator=0, multiplicand=A, multiplier=B latched.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - MUL exit: after WIDTH iterations, go to DONE with result=acc. Early exit when multiplier==0 is allowed as long as the result is identical; latency is then <= WIDTH+1.
  - DONE: valid=1 for exactly one cycle, then return to IDLE.
- ready is 1 only in IDLE. start while ready==0 is ignored; no queueing.
- Latency from accept edge to the valid cycle:
  - Single-cycle ops: 1.
  - MUL: WIDTH+1 worst case.
  - Back-to-back: start may be asserted in the cycle after valid, giving one accept every 2 cycles for single-cycle ops.
- Flags, computed on the final result and committed in the same edge that enters DONE, only if set_flags was 1 at accept:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD/SUB: C = carry out of the MSB (SUB: 1 means no borrow); V = carry into MSB XOR carry out of MSB.
  - Logical, PASS, shift and MUL ops: C=0, V=0.
- Flags otherwise hold their value indefinitely.
- Operands and set_flags are captured at accept; input changes afterwards have no effect.
- Shift by 0 returns A; the amount is masked to SH_W bits, so no shift is ever >= WIDTH.

Test Plan:
- Reset held 2 cycles, then released, WIDTH=64 → ready=1, valid=0, result=0, NZVC=0000.
- ADD with set_flags=1, WIDTH=8, A=0x7F, B=0x01 → valid 1 cycle after accept, result=0x80, N=1 Z=0 V=1 C=0.
- SUB with set_flags=1, WIDTH=8, A=0x05, B=0x05 → result=0x00, Z=1 C=1 V=0 N=0. Follow with AND set_flags=0 A=0xF0 B=0x0F → result=0x00, flags still Z=1 C=1.
- MUL, WIDTH=8, A=0x0D, B=0x0B:
  - ready=0 for the whole multiply; start pulses during busy are ignored.
  - Result 0x8F, valid within 9 cycles of accept.
  - With set_flags=1: N=1 Z=0 C=0 V=0.
- MUL, WIDTH=64, A=0xFFFF_FFFF_FFFF_FFFF, B=2 → result=0xFFFF_FFFF_FFFF_FFFE. Then reset pulled low mid-MUL: no valid, ready=1 after reset, result=0.
- LSL/LSR and illegal op, WIDTH=8:
  - LSL A=0x81 B=0x09 (amount masked to 1) → 0x02.
  - LSR A=0x80 B=0x07 → 0x01.
  - Illegal op 1111 with set_flags=1 → result=0, valid pulses, flags unchanged.
